// File: rtl/life_manager.sv
// life_manager: owns the player's life count, runs the respawn delay and the
// game-over state, and drives the life display (value + display enable).
// Optional feature macro: LIFE_BLINK_EN (blinks lifeVisible in RESPAWN/OVER).
module life_manager #(
    parameter int unsigned INITIAL_LIVES  = 3,
    parameter int unsigned MAX_LIVES      = 9,
    parameter int unsigned RESPAWN_FRAMES = 120,
    parameter int unsigned BLINK_FRAMES   = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       ballLost,
    input  logic       bonusLife,
    input  logic       newGame,
    output logic [3:0] life,
    output logic       lifeVisible,
    output logic       respawn,
    output logic       gameOver
);

    localparam logic [1:0] ST_PLAY    = 2'd0;
    localparam logic [1:0] ST_RESPAWN = 2'd1;
    localparam logic [1:0] ST_OVER    = 2'd2;

    localparam logic [3:0] INIT_L   = 4'(INITIAL_LIVES);
    localparam logic [3:0] MAX_L    = 4'(MAX_LIVES);
    localparam logic [7:0] FRAMES_L = 8'(RESPAWN_FRAMES);

    logic [1:0] state, state_nxt;
    logic [3:0] life_q, life_nxt;
    logic [7:0] frame_cnt, frame_nxt;
    logic       respawn_q, respawn_nxt;
    logic       over_q;

    logic [4:0] life_inc5;
    logic [3:0] life_inc;
    logic [3:0] life_dec;
    logic [3:0] life_net;

    // Saturating +1 / -1 helpers; 5-bit add keeps 15 + 1 from wrapping
    always_comb begin
        life_inc5 = {1'b0, life_q} + 5'd1;
        life_inc  = (life_inc5 > {1'b0, MAX_L}) ? MAX_L : life_inc5[3:0];
        life_dec  = (life_q == 4'd0) ? 4'd0 : life_q - 4'd1;
        // ballLost with a same-cycle bonus nets to the current count, clipped
        life_net  = bonusLife ? ((life_q > MAX_L) ? MAX_L : life_q) : life_dec;
    end

    // Next-state logic; priority newGame > ballLost > bonusLife > frame counting
    always_comb begin
        state_nxt   = state;
        life_nxt    = life_q;
        frame_nxt   = frame_cnt;
        respawn_nxt = 1'b0;
        if (newGame) begin
            state_nxt = ST_PLAY;
            life_nxt  = INIT_L;
            frame_nxt = '0;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (ballLost) begin
                        life_nxt = life_net;
                        if (life_net == 4'd0) begin
                            state_nxt = ST_OVER;
                            frame_nxt = '0;
                        end else begin
                            state_nxt = ST_RESPAWN;
                            frame_nxt = FRAMES_L;
                        end
                    end else if (bonusLife) begin
                        life_nxt = life_inc;
                    end
                end
                ST_RESPAWN: begin
                    if (bonusLife) begin
                        life_nxt = life_inc;
                    end
                    if (startOfFrame) begin
                        if (frame_cnt <= 8'd1) begin
                            state_nxt   = ST_PLAY;
                            frame_nxt   = '0;
                            respawn_nxt = 1'b1;
                        end else begin
                            frame_nxt = frame_cnt - 8'd1;
                        end
                    end
                end
                ST_OVER: begin
                    life_nxt = 4'd0;
                end
                default: begin
                    state_nxt = ST_PLAY;
                    life_nxt  = INIT_L;
                    frame_nxt = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= ST_PLAY;
            life_q    <= INIT_L;
            frame_cnt <= '0;
            respawn_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            life_q    <= life_nxt;
            frame_cnt <= frame_nxt;
            respawn_q <= respawn_nxt;
            over_q    <= (state_nxt == ST_OVER);
        end
    end

    assign life     = life_q;
    assign respawn  = respawn_q;
    assign gameOver = over_q;

`ifdef LIFE_BLINK_EN
    localparam logic [4:0] BLINK_LAST = 5'(BLINK_FRAMES - 1);

    logic [4:0] blink_cnt, blink_nxt;
    logic       vis_q, vis_nxt;

    // Blink sequencing: solid in PLAY, restart dark on leaving PLAY, then
    // toggle every BLINK_FRAMES frames while in RESPAWN or OVER
    always_comb begin
        blink_nxt = blink_cnt;
        vis_nxt   = vis_q;
        if (state_nxt == ST_PLAY) begin
            blink_nxt = '0;
            vis_nxt   = 1'b1;
        end else if (state == ST_PLAY) begin
            blink_nxt = '0;
            vis_nxt   = 1'b0;
        end else if (startOfFrame) begin
            if (blink_cnt >= BLINK_LAST) begin
                blink_nxt = '0;
                vis_nxt   = ~vis_q;
            end else begin
                blink_nxt = blink_cnt + 5'd1;
            end
        end
    end

    // Blink registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt <= '0;
            vis_q     <= 1'b1;
        end else begin
            blink_cnt <= blink_nxt;
            vis_q     <= vis_nxt;
        end
    end

    assign lifeVisible = vis_q;
`else
    assign lifeVisible = 1'b1;
`endif

endmodule
